adc_level_monitor: RTL and testbench

//  Multi-channel successor to the single-channel XADC threshold/LED decoder.

---
 rtl/adc_level_monitor.sv | 84 ++++++++
 tb/tb_adc_level_monitor.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/adc_level_monitor.sv
// adc_level_monitor: per-channel ADC band quantiser with hysteresis, persistence filter and LED bar
// ports: clk, RESET_N (sync, active-low); sample_valid/sample_chan/sample_data in;
//        sel_chan picks the led channel; level (packed committed bands), top_alarm,
//        change_valid/change_chan (commit pulse), led (one-hot of level[sel_chan])
module adc_level_monitor #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int NUM_LEVELS = 4,
  parameter int unsigned HYST = 32'h200,
  parameter int PERSIST = 3,
  localparam int LVL_W = $clog2(NUM_LEVELS),
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    RESET_N,
  input  logic                    sample_valid,
  input  logic [CH_W-1:0]         sample_chan,
  input  logic [DATA_W-1:0]       sample_data,
  input  logic [CH_W-1:0]         sel_chan,
  output logic [NUM_CH*LVL_W-1:0] level,
  output logic [NUM_CH-1:0]       top_alarm,
  output logic                    change_valid,
  output logic [CH_W-1:0]         change_chan,
  output logic [NUM_LEVELS-1:0]   led
);
  localparam int CNT_W = $clog2(PERSIST + 1);
  localparam int W = DATA_W + 2;
  localparam logic [W-1:0] HY = W'(HYST);
  localparam logic [W-1:0] BW = W'(1) << (DATA_W - LVL_W);
  logic [LVL_W-1:0] lvl [NUM_CH];
  logic [LVL_W-1:0] pend [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic hit, sel_ok, up, dn, commit;
  logic [CH_W-1:0] ci, si;
  logic [LVL_W-1:0] raw, cur, tgt;
  logic [W-1:0] lo, d;
  logic [CNT_W-1:0] m;
  always_comb begin
    hit = sample_valid && 32'(sample_chan) < NUM_CH;
    sel_ok = 32'(sel_chan) < NUM_CH;
    ci = hit ? sample_chan : '0;
    si = sel_ok ? sel_chan : '0;
    cur = lvl[ci];
    raw = sample_data[DATA_W-1 -: LVL_W];
    lo = W'(raw) << (DATA_W - LVL_W);
    d = W'(sample_data);
    // margins evaluated with the hysteresis moved to the other side so nothing underflows
    up = d >= lo + HY;
    dn = d + HY < lo + BW;
    tgt = ((raw > cur && up) || (raw < cur && dn)) ? raw : cur;
    m = (cnt[ci] != '0 && tgt == pend[ci]) ? cnt[ci] + CNT_W'(1) : CNT_W'(1);
    commit = hit && tgt != cur && 32'(m) >= PERSIST;
  end
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lvl[i] <= '0;
        pend[i] <= '0;
        cnt[i] <= '0;
      end
      change_valid <= 1'b0;
      change_chan <= '0;
      led <= NUM_LEVELS'(1);
    end else begin
      change_valid <= commit;
      if (commit) change_chan <= ci;
      led <= sel_ok ? NUM_LEVELS'(1) << lvl[si] : '0;
      if (hit) begin
        if (tgt == cur) cnt[ci] <= '0;
        else if (commit) begin
          lvl[ci] <= tgt;
          cnt[ci] <= '0;
        end else begin
          pend[ci] <= tgt;
          cnt[ci] <= m;
        end
      end
    end
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign level[k*LVL_W +: LVL_W] = lvl[k];
    assign top_alarm[k] = lvl[k] == LVL_W'(NUM_LEVELS - 1);
  end
endmodule

// File: tb/tb_adc_level_monitor.sv
// tb_adc_level_monitor: directed checks of banding, hysteresis, persistence, interleave and reset
module tb_adc_level_monitor;
  logic clk = 0, RESET_N = 0, sample_valid = 0;
  logic [1:0] sample_chan = 0, sel_chan = 2, sel3 = 3;
  logic [15:0] sample_data = 0;
  logic [7:0] level;
  logic [3:0] top_alarm, led, led3;
  logic change_valid, change_valid3;
  logic [1:0] change_chan, change_chan3;
  logic [5:0] level3;
  logic [2:0] top_alarm3;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  adc_level_monitor dut (
    .clk(clk), .RESET_N(RESET_N), .sample_valid(sample_valid), .sample_chan(sample_chan),
    .sample_data(sample_data), .sel_chan(sel_chan), .level(level), .top_alarm(top_alarm),
    .change_valid(change_valid), .change_chan(change_chan), .led(led));

  adc_level_monitor #(.NUM_CH(3)) dut3 (
    .clk(clk), .RESET_N(RESET_N), .sample_valid(sample_valid), .sample_chan(sample_chan),
    .sample_data(sample_data), .sel_chan(sel3), .level(level3), .top_alarm(top_alarm3),
    .change_valid(change_valid3), .change_chan(change_chan3), .led(led3));

  task automatic send(input logic [1:0] ch, input logic [15:0] dat);
    sample_valid = 1;
    sample_chan = ch;
    sample_data = dat;
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic test_reset;
    RESET_N = 0;
    repeat (2) @(negedge clk);
    RESET_N = 1;
    @(negedge clk);
    checks++; if (level !== 8'h00) begin failures++; $display("FAIL reset_level got=%h exp=00", level); end
    checks++; if (top_alarm !== 4'b0000) begin failures++; $display("FAIL reset_alarm got=%b exp=0000", top_alarm); end
    checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL reset_cv got=%b exp=0", change_valid); end
    checks++; if (led !== 4'b0001) begin failures++; $display("FAIL reset_led got=%b exp=0001", led); end
  endtask

  task automatic test_commit;
    for (int i = 0; i < 2; i++) begin
      send(2, 16'h5000);
      checks++; if (change_valid !== 1'b0 || level !== 8'h00) begin failures++; $display("FAIL commit_early%0d cv=%b level=%h exp cv=0 level=00", i, change_valid, level); end
    end
    send(2, 16'h5000);
    checks++; if (change_valid !== 1'b1 || change_chan !== 2'd2) begin failures++; $display("FAIL commit_pulse cv=%b ch=%0d exp cv=1 ch=2", change_valid, change_chan); end
    checks++; if (level !== 8'h10) begin failures++; $display("FAIL commit_level got=%h exp=10", level); end
    checks++; if (led !== 4'b0001) begin failures++; $display("FAIL commit_led_lag got=%b exp=0001", led); end
    @(negedge clk);
    checks++; if (led !== 4'b0010) begin failures++; $display("FAIL commit_led got=%b exp=0010", led); end
    checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL commit_pulse_end got=%b exp=0", change_valid); end
  endtask

  task automatic test_hysteresis;
    for (int i = 0; i < 5; i++) begin
      send(0, 16'h41FF);
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL hyst_up_short%0d cv=%b exp=0", i, change_valid); end
    end
    checks++; if (level !== 8'h10) begin failures++; $display("FAIL hyst_up_hold got=%h exp=10", level); end
    repeat (3) send(0, 16'h4200);
    checks++; if (level !== 8'h11 || change_valid !== 1'b1 || change_chan !== 2'd0) begin failures++; $display("FAIL hyst_up level=%h cv=%b ch=%0d exp 11/1/0", level, change_valid, change_chan); end
    for (int i = 0; i < 3; i++) begin
      send(0, 16'h3E00);
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL hyst_dn_short%0d cv=%b exp=0", i, change_valid); end
    end
    checks++; if (level !== 8'h11) begin failures++; $display("FAIL hyst_dn_hold got=%h exp=11", level); end
    repeat (3) send(0, 16'h3DFF);
    checks++; if (level !== 8'h10 || change_valid !== 1'b1) begin failures++; $display("FAIL hyst_dn level=%h cv=%b exp 10/1", level, change_valid); end
  endtask

  task automatic test_interrupt;
    send(1, 16'h9000);
    send(1, 16'h9000);
    send(1, 16'h1000);
    send(1, 16'h9000);
    checks++; if (level !== 8'h10 || change_valid !== 1'b0) begin failures++; $display("FAIL intr_hold level=%h cv=%b exp 10/0", level, change_valid); end
    send(1, 16'h9000);
    checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL intr_early cv=%b exp=0", change_valid); end
    send(1, 16'h9000);
    checks++; if (level !== 8'h18 || change_chan !== 2'd1 || change_valid !== 1'b1) begin failures++; $display("FAIL intr_commit level=%h ch=%0d cv=%b exp 18/1/1", level, change_chan, change_valid); end
    repeat (3) send(3, 16'hF000);
    checks++; if (level !== 8'hD8 || top_alarm !== 4'b1000) begin failures++; $display("FAIL top_level level=%h alarm=%b exp D8/1000", level, top_alarm); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1;
      sample_chan = 2'(i % 2);
      sample_data = 16'hC800;
      @(negedge clk);
      checks++; if (change_valid !== (i >= 4) || (i >= 4 && change_chan !== 2'(i % 2))) begin failures++; $display("FAIL b2b_%0d cv=%b ch=%0d exp cv=%0d ch=%0d", i, change_valid, change_chan, i >= 4, i % 2); end
    end
    sample_valid = 0;
    checks++; if (level !== 8'hDF || top_alarm !== 4'b1011) begin failures++; $display("FAIL b2b_level level=%h alarm=%b exp DF/1011", level, top_alarm); end
    for (int i = 0; i < 3; i++) begin
      send(3, 16'h5000);
      checks++; if (change_valid3 !== 1'b0) begin failures++; $display("FAIL ch_oob_pulse%0d cv=%b exp=0", i, change_valid3); end
    end
    checks++; if (level !== 8'h5F || change_valid !== 1'b1) begin failures++; $display("FAIL ch3_down level=%h cv=%b exp 5F/1", level, change_valid); end
    checks++; if (level3 !== 6'h1F || top_alarm3 !== 3'b011) begin failures++; $display("FAIL ch_oob_state level=%h alarm=%b exp 1F/011", level3, top_alarm3); end
    checks++; if (led3 !== 4'b0000) begin failures++; $display("FAIL sel_oob_led got=%b exp=0000", led3); end
  endtask

  task automatic test_reset_midop;
    send(2, 16'hF000);
    send(2, 16'hF000);
    RESET_N = 0;
    sample_valid = 1;
    sample_chan = 2;
    sample_data = 16'hF000;
    @(negedge clk);
    RESET_N = 1;
    sample_valid = 0;
    checks++; if (level !== 8'h00 || change_valid !== 1'b0 || led !== 4'b0001) begin failures++; $display("FAIL midrst_state level=%h cv=%b led=%b exp 00/0/0001", level, change_valid, led); end
    send(2, 16'hF000);
    checks++; if (level !== 8'h00 || change_valid !== 1'b0) begin failures++; $display("FAIL midrst_nocommit level=%h cv=%b exp 00/0", level, change_valid); end
    send(2, 16'hF000);
    checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL midrst_second cv=%b exp=0", change_valid); end
    send(2, 16'hF000);
    checks++; if (level !== 8'h30 || change_valid !== 1'b1) begin failures++; $display("FAIL midrst_commit level=%h cv=%b exp 30/1", level, change_valid); end
    @(negedge clk);
    checks++; if (led !== 4'b1000) begin failures++; $display("FAIL midrst_led got=%b exp=1000", led); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_commit;
    test_hysteresis;
    test_interrupt;
    test_back_to_back;
    test_reset_midop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
